// File: rtl/iron_violet_simon_if.sv
`default_nettype none
// ============================================================================
//  Module      : iron_violet_simon_if
//  Description : Tile pin bundle for the Simon game (buttons, lamps, length)
//  Revision    : 1.0  initial release
// ============================================================================
interface iron_violet_simon_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // Driver side (board / test harness)
    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    // Game side
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface
`default_nettype wire

// File: rtl/iron_violet_simon.sv
`default_nettype none
// ============================================================================
//  Module      : iron_violet_simon
//  Description : Four-colour Simon memory game. The sequence is regenerated
//                from a stored LFSR seed for both the show and the replay
//                check, so no sequence memory is needed.
//  Revision    : 1.0  initial release
// ============================================================================
module iron_violet_simon #(
    parameter int unsigned ON_CYC      = 25_000_000,
    parameter int unsigned GAP_CYC     = 12_500_000,
    parameter int unsigned TIMEOUT_CYC = 250_000_000,
    parameter int unsigned DEB_CYC     = 250_000,
    parameter int unsigned MAX_LEN     = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    iron_violet_simon_if.slave  bus
);

    localparam logic [15:0] c_SEED_DEF = 16'hACE1;
    localparam logic [15:0] c_TAPS     = 16'hB400;
    localparam int          c_DW       = $clog2(DEB_CYC + 1);
    localparam logic [31:0] c_ON_LAST  = 32'(ON_CYC - 1);
    localparam logic [31:0] c_GAP_LAST = 32'(GAP_CYC - 1);
    localparam logic [31:0] c_TO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  c_MAX_LEN  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_PAUSE, S_SHOW_ON, S_SHOW_OFF,
        S_INPUT, S_BLINK_ON, S_BLINK_OFF, S_ENDED
    } state_t;

    function automatic logic [15:0] f_lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? c_TAPS : 16'h0000);
    endfunction

    logic [7:0]      r_sync1, r_sync2, r_deb, r_deb_q;
    logic [c_DW-1:0] r_dcnt [8];
    logic [15:0]     r_free;

    state_t      r_state, w_state;
    logic [31:0] r_timer, w_timer;
    logic [7:0]  r_len, w_len, r_idx, w_idx;
    logic [15:0] r_seed, w_seed, r_lfsr, w_lfsr;
    logic [1:0]  r_blink, w_blink;
    logic        r_win, w_win, r_won, w_won, r_lost, w_lost;
    logic [3:0]  w_lamps;
    logic        w_playing;

    logic [7:0]  w_press;
    logic [3:0]  w_step_lamp;
    logic        w_any, w_multi;
    logic        w_unused;

    assign w_press     = r_deb & ~r_deb_q;
    assign w_step_lamp = 4'd1 << r_lfsr[1:0];
    assign w_any       = |w_press[3:0];
    assign w_multi     = (w_press[3:0] & (w_press[3:0] - 4'd1)) != 4'd0;
    assign w_unused    = ^{bus.ena, bus.uio_in, w_press[7:6], w_press[4]};

    // Two-flop synchroniser, per-bit debounce and free-running seed counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            r_free  <= '0;
            for (int i = 0; i < 8; i++) r_dcnt[i] <= '0;
        end else begin
            r_sync1 <= bus.ui_in;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            r_free  <= r_free + 16'd1;
            for (int i = 0; i < 8; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == c_DW'(DEB_CYC - 1)) begin
                    r_deb[i]  <= r_sync2[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Game state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_seed  <= '0;
            r_lfsr  <= '0;
            r_blink <= '0;
            r_win   <= 1'b0;
            r_won   <= 1'b0;
            r_lost  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_timer <= w_timer;
            r_len   <= w_len;
            r_idx   <= w_idx;
            r_seed  <= w_seed;
            r_lfsr  <= w_lfsr;
            r_blink <= w_blink;
            r_win   <= w_win;
            r_won   <= w_won;
            r_lost  <= w_lost;
        end
    end

    // Next-state, datapath updates and lamp/flag outputs
    always_comb begin
        w_state   = r_state;
        w_timer   = r_timer + 32'd1;
        w_len     = r_len;
        w_idx     = r_idx;
        w_seed    = r_seed;
        w_lfsr    = r_lfsr;
        w_blink   = r_blink;
        w_win     = r_win;
        w_won     = r_won;
        w_lost    = r_lost;
        w_lamps   = 4'h0;
        w_playing = 1'b0;
        case (r_state)
            S_IDLE, S_ENDED: begin
                w_timer = '0;
                if (w_press[5]) begin
                    // A zero seed would lock the LFSR, so it falls back to the default
                    w_seed  = (r_deb[6] || r_free == 16'd0) ? c_SEED_DEF : r_free;
                    w_len   = 8'd1;
                    w_won   = 1'b0;
                    w_lost  = 1'b0;
                    w_state = S_PAUSE;
                end
            end
            S_PAUSE: begin
                w_playing = 1'b1;
                if (r_timer == c_GAP_LAST) begin
                    w_state = S_SHOW_ON;
                    w_timer = '0;
                    w_idx   = '0;
                    w_lfsr  = f_lfsr_next(r_seed);
                end
            end
            S_SHOW_ON: begin
                w_playing = 1'b1;
                w_lamps   = w_step_lamp;
                if (r_timer == c_ON_LAST) begin
                    w_state = S_SHOW_OFF;
                    w_timer = '0;
                end
            end
            S_SHOW_OFF: begin
                w_playing = 1'b1;
                if (r_timer == c_GAP_LAST) begin
                    w_timer = '0;
                    if (r_idx == r_len - 8'd1) begin
                        // Rewind to the first step for the player's replay
                        w_state = S_INPUT;
                        w_idx   = '0;
                        w_lfsr  = f_lfsr_next(r_seed);
                    end else begin
                        w_state = S_SHOW_ON;
                        w_idx   = r_idx + 8'd1;
                        w_lfsr  = f_lfsr_next(r_lfsr);
                    end
                end
            end
            S_INPUT: begin
                w_playing = 1'b1;
                w_lamps   = r_deb[3:0];
                if (w_multi || (w_any && w_press[3:0] != w_step_lamp) ||
                    (!w_any && r_timer == c_TO_LAST)) begin
                    w_state = S_BLINK_ON;
                    w_timer = '0;
                    w_blink = '0;
                    w_win   = 1'b0;
                end else if (w_any) begin
                    w_timer = '0;
                    if (r_idx != r_len - 8'd1) begin
                        w_idx  = r_idx + 8'd1;
                        w_lfsr = f_lfsr_next(r_lfsr);
                    end else if (r_len == c_MAX_LEN) begin
                        w_state = S_BLINK_ON;
                        w_blink = '0;
                        w_win   = 1'b1;
                    end else begin
                        w_state = S_PAUSE;
                        w_len   = r_len + 8'd1;
                    end
                end
            end
            S_BLINK_ON: begin
                w_lamps = 4'hF;
                if (r_timer == c_ON_LAST) begin
                    w_state = S_BLINK_OFF;
                    w_timer = '0;
                end
            end
            S_BLINK_OFF: begin
                if (r_timer == c_ON_LAST) begin
                    w_timer = '0;
                    if (r_blink == 2'd2) begin
                        w_state = S_ENDED;
                        w_won   = r_win;
                        w_lost  = ~r_win;
                    end else begin
                        w_state = S_BLINK_ON;
                        w_blink = r_blink + 2'd1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_timer = '0;
            end
        endcase
    end

    assign bus.uo_out  = {1'b0, r_won, r_lost, w_playing, w_lamps};
    assign bus.uio_out = r_len;
    assign bus.uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_iron_violet_simon.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iron_violet_simon
//  Description : Randomised self-checking bench for the Simon game
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iron_violet_simon;

    localparam int ON   = 8;
    localparam int GAP  = 4;
    localparam int TO   = 200;
    localparam int DEB  = 2;
    localparam int MAXL = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iron_violet_simon_if bus();

    iron_violet_simon #(
        .ON_CYC(ON), .GAP_CYC(GAP), .TIMEOUT_CYC(TO), .DEB_CYC(DEB), .MAX_LEN(MAXL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [3:0] lamp; logic [7:0] len; } show_t;
    typedef struct { logic won; logic lost; logic [7:0] len; } end_t;

    show_t q_show[$];
    end_t  q_end[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Colour of step k: k+1 Galois-LFSR advances from the fixed test seed
    function automatic logic [1:0] ref_col(input int k);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i <= k; i++) l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        return l[1:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_round(input int len);
        show_t s;
        for (int k = 0; k < len; k++) begin
            s.lamp = 4'b0001 << ref_col(k);
            s.len  = 8'(len);
            q_show.push_back(s);
        end
    endtask

    task automatic wait_show(input int budget);
        int n = 0;
        while (q_show.size() != 0 && n < budget) begin tick(1); n++; end
        if (q_show.size() != 0) begin
            chk("show_wait_expired", q_show.size(), 0);
            q_show.delete();
        end
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (q_end.size() != 0 && n < budget) begin tick(1); n++; end
        if (q_end.size() != 0) begin
            chk("end_wait_expired", q_end.size(), 0);
            q_end.delete();
        end
    endtask

    task automatic push_end(input logic won, input logic lost, input int len);
        end_t e;
        e.won = won; e.lost = lost; e.len = 8'(len);
        q_end.push_back(e);
    endtask

    task automatic pulse(input logic [3:0] mask);
        bus.ui_in[3:0] = mask;
        tick(6);
        bus.ui_in[3:0] = 4'h0;
        tick(6);
    endtask

    // fail_round 0 plays to a win; otherwise kind 1=wrong colour, 2=double, 3=timeout
    task automatic game(input int fail_round, input int fail_step, input int kind);
        logic [3:0] mask;
        int a, b;
        push_round(1);
        bus.ui_in[5] = 1'b1;
        tick(6);
        bus.ui_in[5] = 1'b0;
        chk("start_flags", 32'(bus.uo_out[6:4]), 32'h1);
        chk("start_len", 32'(bus.uio_out), 32'd1);
        for (int len = 1; len <= MAXL; len++) begin
            wait_show(40 * len + 100);
            tick(8);
            for (int s = 0; s < len; s++) begin
                if (len == fail_round && s == fail_step) begin
                    push_end(1'b0, 1'b1, len);
                    if (kind == 1) begin
                        mask = 4'b0001 << ((32'(ref_col(s)) + 1 + $urandom_range(0, 2)) % 4);
                        pulse(mask);
                    end else if (kind == 2) begin
                        a = $urandom_range(0, 3);
                        b = (a + 1 + $urandom_range(0, 2)) % 4;
                        mask = (4'b0001 << a) | (4'b0001 << b);
                        pulse(mask);
                    end
                    wait_end(600);
                    return;
                end
                mask = 4'b0001 << ref_col(s);
                bus.ui_in[3:0] = mask;
                tick(6);
                if (s == len - 1) begin
                    if (len == MAXL) push_end(1'b1, 1'b0, MAXL);
                    else             push_round(len + 1);
                end else begin
                    chk("input_mirror", 32'(bus.uo_out[3:0]), 32'(mask));
                end
                bus.ui_in[3:0] = 4'h0;
                tick(6 + $urandom_range(0, 20));
            end
        end
        wait_end(600);
    endtask

    // Monitor: pops expected show steps and game endings as the DUT presents them
    logic [3:0] m_prev_lamps = 4'h0;
    logic [3:0] m_lamp;
    logic [7:0] m_len;
    logic       m_prev_won = 1'b0, m_prev_lost = 1'b0, m_in_show = 1'b0;
    int         m_dur = 0, m_blinks = 0;
    show_t      m_s;
    end_t       m_e;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_in_show = 1'b0; m_prev_lamps = 4'h0;
                m_prev_won = 1'b0; m_prev_lost = 1'b0; m_blinks = 0;
                continue;
            end
            if (!m_in_show && q_show.size() != 0 && m_prev_lamps == 4'h0 && bus.uo_out[3:0] != 4'h0) begin
                m_in_show = 1'b1;
                m_lamp    = bus.uo_out[3:0];
                m_len     = bus.uio_out;
                m_dur     = 1;
                chk("show_playing", 32'(bus.uo_out[4]), 32'h1);
            end else if (m_in_show && bus.uo_out[3:0] == m_lamp) begin
                m_dur++;
            end else if (m_in_show) begin
                m_in_show = 1'b0;
                if (q_show.size() != 0) begin
                    m_s = q_show.pop_front();
                    chk("show_lamp", 32'(m_lamp), 32'(m_s.lamp));
                    chk("show_len", 32'(m_len), 32'(m_s.len));
                    chk("show_on_cycles", m_dur, ON);
                end
            end
            if (bus.uo_out[4]) m_blinks = 0;
            else if (bus.uo_out[3:0] == 4'hF && m_prev_lamps != 4'hF) m_blinks++;
            if ((bus.uo_out[6] && !m_prev_won) || (bus.uo_out[5] && !m_prev_lost)) begin
                if (q_end.size() == 0) begin
                    chk("unexpected_end", 32'(bus.uo_out[6:5]), 32'h0);
                end else begin
                    m_e = q_end.pop_front();
                    chk("end_won", 32'(bus.uo_out[6]), 32'(m_e.won));
                    chk("end_lost", 32'(bus.uo_out[5]), 32'(m_e.lost));
                    chk("end_len", 32'(bus.uio_out), 32'(m_e.len));
                    chk("end_blinks", m_blinks, 3);
                    chk("end_lamps_playing", 32'(bus.uo_out[4:0]), 32'h0);
                end
            end
            m_prev_lamps = bus.uo_out[3:0];
            m_prev_won   = bus.uo_out[6];
            m_prev_lost  = bus.uo_out[5];
        end
    end

    initial begin
        int kind, fr, fs;
        bus.ena    = 1'b1;
        bus.uio_in = 8'h00;
        bus.ui_in  = 8'h4F;
        tick(5);
        chk("rst_hold_uo", 32'(bus.uo_out), 32'h0);
        chk("rst_hold_uio", 32'(bus.uio_out), 32'h0);
        chk("rst_uio_oe", 32'(bus.uio_oe), 32'hFF);
        tick(5);
        chk("rst_hold_uo_late", 32'(bus.uo_out), 32'h0);
        bus.ui_in = 8'h40;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_uo", 32'(bus.uo_out), 32'h0);
        chk("post_rst_uio", 32'(bus.uio_out), 32'h0);

        game(0, 0, 0);
        game(1, 0, 1);
        game(1, 0, 3);
        game(2, 1, 2);
        for (int g = 0; g < 8; g++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                game(0, 0, 0);
            end else begin
                fr = $urandom_range(1, MAXL);
                fs = $urandom_range(0, fr - 1);
                game(fr, fs, kind);
            end
        end

        // Reset in the middle of a game
        push_round(1);
        bus.ui_in[5] = 1'b1;
        tick(6);
        bus.ui_in[5] = 1'b0;
        tick(14);
        rst_n = 1'b0;
        tick(1);
        chk("midgame_rst_uo", 32'(bus.uo_out), 32'h0);
        chk("midgame_rst_uio", 32'(bus.uio_out), 32'h0);
        q_show.delete();
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("after_rst_idle_uo", 32'(bus.uo_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
